// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// The fetch-queue entry carries a PC_W-bit PC; fetch_unit XLEN must not exceed PC_W.
package fetch_pkg;

   localparam int unsigned PC_W        = 32;
   localparam int unsigned INSTR_BYTES = 4;
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [31:0]     instr;
      logic            misaligned;
   } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with flush; DEPTH must be a power of two.
// Pointers carry a wrap bit so full and empty are distinguishable.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             nrst,
   input  logic                             flush,
   input  logic                             push,
   input  fq_entry_t                        push_entry,
   input  logic                             pop,
   output fq_entry_t                        head,
   output logic                             valid,
   output logic [$clog2(DEPTH+1)-1:0]       count
);

   localparam int unsigned AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   fq_entry_t   mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr[AW-1:0]] <= push_entry;
   end

   assign head  = mem[rd_ptr[AW-1:0]];
   assign valid = (wr_ptr != rd_ptr);
   assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, credit-based issue to a 1-cycle imem, fetch queue to decode.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned fetch PCs instead of masking address bits.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned     XLEN        = 32,
   parameter int unsigned     FETCH_DEPTH = 4,
   parameter logic [XLEN-1:0] RESET_PC    = '0
) (
   input  logic                               clk,
   input  logic                               nrst,
   input  logic                               redirect_i,
   input  logic [XLEN-1:0]                    redirect_pc_i,
   input  logic                               trap_i,
   input  logic [XLEN-1:0]                    trap_vec_i,
   output logic                               imem_req_o,
   output logic [XLEN-1:0]                    imem_addr_o,
   input  logic [31:0]                        imem_rdata_i,
   output logic                               dec_valid_o,
   input  logic                               dec_ready_i,
   output logic [XLEN-1:0]                    dec_pc_o,
   output logic [31:0]                        dec_instr_o,
   output logic                               dec_misaligned_o,
   output logic [$clog2(FETCH_DEPTH+1)-1:0]   fq_count_o
);

   localparam int unsigned CW = $clog2(FETCH_DEPTH+1);

`ifdef FETCH_MISALIGN_CHECK_EN
   localparam bit MISALIGN_CHECK = 1'b1;
`else
   localparam bit MISALIGN_CHECK = 1'b0;
`endif

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] inflight_pc;
   logic            inflight;
   logic            halted;

   logic            flush;
   logic [XLEN-1:0] flush_pc;
   logic            pop;
   logic            push;
   logic [CW:0]     occupancy;
   logic            issue_slot;
   logic            misaligned;
   fq_entry_t       push_entry;
   fq_entry_t       head;
   logic            fq_valid;
   logic [CW-1:0]   fq_count;

   assign flush    = trap_i | redirect_i;
   assign flush_pc = trap_i ? trap_vec_i : redirect_pc_i;

   // Masking the head during a flush keeps decode from consuming a dying entry.
   assign dec_valid_o = fq_valid & ~flush;
   assign pop         = dec_valid_o & dec_ready_i;

   // Credits: queued + in flight, less the entry leaving this cycle.
   assign occupancy  = {1'b0, fq_count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
   assign issue_slot = nrst & ~halted & ~flush & (occupancy < (CW+1)'(FETCH_DEPTH));

   assign misaligned  = MISALIGN_CHECK && (pc[1:0] != 2'b00);
   assign imem_req_o  = issue_slot & ~misaligned;
   assign imem_addr_o = MISALIGN_CHECK ? pc : {pc[XLEN-1:2], 2'b00};

   // A misaligned PC is never issued, so it cannot collide with a pending response.
   assign push = (inflight & ~flush) | (issue_slot & misaligned);

   always_comb begin
      push_entry = '0;
      if (inflight) begin
         push_entry.pc         = PC_W'(inflight_pc);
         push_entry.instr      = imem_rdata_i;
         push_entry.misaligned = 1'b0;
      end else begin
         push_entry.pc         = PC_W'(pc);
         push_entry.instr      = NOP_INSTR;
         push_entry.misaligned = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         halted      <= 1'b0;
      end else if (flush) begin
         pc       <= flush_pc;
         inflight <= 1'b0;
         halted   <= 1'b0;
      end else if (imem_req_o) begin
         pc          <= pc + XLEN'(INSTR_BYTES);
         inflight    <= 1'b1;
         inflight_pc <= pc;
      end else begin
         inflight <= 1'b0;
         if (issue_slot && misaligned) halted <= 1'b1;
      end
   end

   fetch_queue #(
      .DEPTH (FETCH_DEPTH)
   ) u_fetch_queue (
      .clk        (clk),
      .nrst       (nrst),
      .flush      (flush),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .valid      (fq_valid),
      .count      (fq_count)
   );

   assign dec_pc_o         = fq_valid ? XLEN'(head.pc) : '0;
   assign dec_instr_o      = fq_valid ? head.instr : '0;
   assign dec_misaligned_o = MISALIGN_CHECK && fq_valid && head.misaligned;
   assign fq_count_o       = fq_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, back-pressure, redirect/trap flush, misalignment, reset.
// Memory returns addr ^ 0x13570000 one cycle after each request.
module tb_fetch_unit;

   logic        clk;
   logic        nrst;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        trap_i;
   logic [31:0] trap_vec_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_rdata_i;
   logic        dec_valid_o;
   logic        dec_ready_i;
   logic [31:0] dec_pc_o;
   logic [31:0] dec_instr_o;
   logic        dec_misaligned_o;
   logic [2:0]  fq_count_o;

   int checks = 0;
   int errors = 0;

   fetch_unit #(
      .XLEN        (32),
      .FETCH_DEPTH (4),
      .RESET_PC    (32'h0)
   ) dut (
      .clk              (clk),
      .nrst             (nrst),
      .redirect_i       (redirect_i),
      .redirect_pc_i    (redirect_pc_i),
      .trap_i           (trap_i),
      .trap_vec_i       (trap_vec_i),
      .imem_req_o       (imem_req_o),
      .imem_addr_o      (imem_addr_o),
      .imem_rdata_i     (imem_rdata_i),
      .dec_valid_o      (dec_valid_o),
      .dec_ready_i      (dec_ready_i),
      .dec_pc_o         (dec_pc_o),
      .dec_instr_o      (dec_instr_o),
      .dec_misaligned_o (dec_misaligned_o),
      .fq_count_o       (fq_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h1357_0000;
   endfunction

   always @(posedge clk) begin
      if (imem_req_o) imem_rdata_i <= instr_of(imem_addr_o);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   logic exp_req [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   int   exp_cnt [5] = '{1, 2, 3, 4, 4};

   initial begin
      nrst          = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = '0;
      trap_i        = 1'b0;
      trap_vec_i    = '0;
      dec_ready_i   = 1'b1;
      #1;
      check("rst_req",   imem_req_o,       0);
      check("rst_addr",  imem_addr_o,      32'h0);
      check("rst_valid", dec_valid_o,      0);
      check("rst_count", fq_count_o,       0);
      check("rst_pc",    dec_pc_o,         0);
      check("rst_instr", dec_instr_o,      0);
      check("rst_mis",   dec_misaligned_o, 0);

      // Streaming from reset: cycles 0..7
      @(negedge clk);
      nrst = 1'b1;
      #1;
      for (int c = 0; c < 8; c++) begin
         if (c > 0) begin
            next_cycle();
            #1;
         end
         check("str_req",  imem_req_o,  1);
         check("str_addr", imem_addr_o, 32'(4 * c));
         if (c >= 2) begin
            check("str_valid", dec_valid_o, 1);
            check("str_pc",    dec_pc_o,    32'(4 * (c - 2)));
            check("str_instr", dec_instr_o, instr_of(32'(4 * (c - 2))));
         end else begin
            check("str_novalid", dec_valid_o, 0);
         end
      end

      // Back-pressure: cycles 8..12
      for (int k = 0; k < 5; k++) begin
         next_cycle();
         if (k == 0) dec_ready_i = 1'b0;
         #1;
         check("stall_req",   imem_req_o,  exp_req[k]);
         check("stall_count", fq_count_o,  exp_cnt[k]);
         check("stall_valid", dec_valid_o, 1);
         check("stall_pc",    dec_pc_o,    32'd24);
      end

      // Resume, in-order drain: cycles 13..17
      for (int k = 0; k < 5; k++) begin
         next_cycle();
         if (k == 0) dec_ready_i = 1'b1;
         #1;
         check("drain_valid", dec_valid_o, 1);
         check("drain_pc",    dec_pc_o,    32'(24 + 4 * k));
         check("drain_instr", dec_instr_o, instr_of(32'(24 + 4 * k)));
         check("drain_req",   imem_req_o,  1);
         check("drain_addr",  imem_addr_o, 32'(40 + 4 * k));
      end

      // Redirect with 3 queued and one in flight: cycle 18
      next_cycle();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h100;
      #1;
      check("redir_req",   imem_req_o,  0);
      check("redir_mask",  dec_valid_o, 0);
      check("redir_count", fq_count_o,  3);
      next_cycle();
      redirect_i = 1'b0;
      #1;
      check("redir1_count", fq_count_o,  0);
      check("redir1_valid", dec_valid_o, 0);
      check("redir1_req",   imem_req_o,  1);
      check("redir1_addr",  imem_addr_o, 32'h100);
      next_cycle();
      #1;
      check("redir2_valid", dec_valid_o, 0);
      check("redir2_count", fq_count_o,  0);
      check("redir2_addr",  imem_addr_o, 32'h104);
      next_cycle();
      #1;
      check("redir3_valid", dec_valid_o, 1);
      check("redir3_pc",    dec_pc_o,    32'h100);
      check("redir3_instr", dec_instr_o, instr_of(32'h100));
      check("redir3_count", fq_count_o,  1);
      next_cycle();
      #1;
      check("redir4_pc", dec_pc_o, 32'h104);

      // Trap and redirect together: trap wins
      next_cycle();
      trap_i        = 1'b1;
      trap_vec_i    = 32'h200;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h100;
      #1;
      check("trap_req",  imem_req_o,  0);
      check("trap_mask", dec_valid_o, 0);
      next_cycle();
      trap_i     = 1'b0;
      redirect_i = 1'b0;
      #1;
      check("trap1_req",   imem_req_o,  1);
      check("trap1_addr",  imem_addr_o, 32'h200);
      check("trap1_count", fq_count_o,  0);
      next_cycle();
      #1;
      check("trap2_addr", imem_addr_o, 32'h204);
      next_cycle();
      #1;
      check("trap3_valid", dec_valid_o, 1);
      check("trap3_pc",    dec_pc_o,    32'h200);

      // Redirect to a misaligned target
      next_cycle();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h102;
      #1;
      check("mis_mask", dec_valid_o, 0);
      next_cycle();
      redirect_i = 1'b0;
      #1;
`ifdef FETCH_MISALIGN_CHECK_EN
      check("mis1_req",   imem_req_o, 0);
      check("mis1_count", fq_count_o, 0);
      next_cycle();
      #1;
      check("mis2_valid", dec_valid_o,      1);
      check("mis2_pc",    dec_pc_o,         32'h102);
      check("mis2_instr", dec_instr_o,      32'h0000_0013);
      check("mis2_flag",  dec_misaligned_o, 1);
      check("mis2_req",   imem_req_o,       0);
      next_cycle();
      #1;
      check("mis3_valid", dec_valid_o, 0);
      check("mis3_req",   imem_req_o,  0);
      check("mis3_count", fq_count_o,  0);
      next_cycle();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h200;
      #1;
      next_cycle();
      redirect_i = 1'b0;
      #1;
      check("mis_resume_req",  imem_req_o,  1);
      check("mis_resume_addr", imem_addr_o, 32'h200);
`else
      check("mis1_req",  imem_req_o,  1);
      check("mis1_addr", imem_addr_o, 32'h100);
      next_cycle();
      #1;
      check("mis2_addr", imem_addr_o, 32'h104);
      next_cycle();
      #1;
      check("mis3_valid", dec_valid_o,      1);
      check("mis3_pc",    dec_pc_o,         32'h102);
      check("mis3_instr", dec_instr_o,      instr_of(32'h100));
      check("mis3_flag",  dec_misaligned_o, 0);
`endif

      // Reset pulsed mid-stream
      next_cycle();
      nrst = 1'b0;
      #1;
      check("mrst_req",   imem_req_o,       0);
      check("mrst_addr",  imem_addr_o,      32'h0);
      check("mrst_valid", dec_valid_o,      0);
      check("mrst_count", fq_count_o,       0);
      check("mrst_pc",    dec_pc_o,         0);
      check("mrst_instr", dec_instr_o,      0);
      check("mrst_mis",   dec_misaligned_o, 0);
      next_cycle();
      nrst = 1'b1;
      #1;
      check("mrst1_req",   imem_req_o,  1);
      check("mrst1_addr",  imem_addr_o, 32'h0);
      check("mrst1_valid", dec_valid_o, 0);
      next_cycle();
      #1;
      check("mrst2_addr",  imem_addr_o, 32'h4);
      check("mrst2_valid", dec_valid_o, 0);
      next_cycle();
      #1;
      check("mrst3_valid", dec_valid_o, 1);
      check("mrst3_pc",    dec_pc_o,    32'h0);
      check("mrst3_instr", dec_instr_o, instr_of(32'h0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
